obi_manager: RTL and testbench
==============================

# obi_manager

Single-outstanding OBI manager (initiator) that converts a simple valid/ready command port into OBI A-channel requests and R-channel responses. It drives the OBI subordinates in this codebase, such as the SRAM subordinate, from any internal client such as a test sequencer, DMA stub or CPU shim. It enforces OBI address-phase stability, buffers one response, and flags stalled transactions via a watchdog.

## Interface
- ADDR_WIDTH, 32: OBI address width; 32 or 64.
- DATA_WIDTH, 32: OBI data width; 32 or 64.
- TIMEOUT_CYCLES, 255: stall cycles (REQ or RWAIT) before `timeout_o` sets; ≥1.
- clk_i  in  1  clock; all logic on rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- cmd_valid_i  in  1  client command valid.
- cmd_ready_o  out  1  manager can accept a command.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  ADDR_WIDTH  byte address.
- cmd_be_i  in  DATA_WIDTH/8  byte enables.
- cmd_wdata_i  in  DATA_WIDTH  write data.
- rsp_valid_o  out  1  response buffered.
- rsp_ready_i  in  1  client consumes response.
- rsp_rdata_o  out  DATA_WIDTH  captured `obi_rdata_i`.
- rsp_err_o  out  1  captured `obi_err_i`.
- timeout_o  out  1  sticky watchdog flag.
- obi_req_o  out  1  OBI request.
- obi_gnt_i  in  1  OBI grant.
- obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o  out  ADDR_WIDTH, 1, DATA_WIDTH/8, DATA_WIDTH  A-channel payload.
- obi_rvalid_i  in  1  R-channel valid.
- obi_rready_o  out  1  R-channel ready.
- obi_rdata_i  in  DATA_WIDTH  read data.
- obi_err_i  in  1  response error.

## Operation
- FSM states: IDLE, REQ, RWAIT, RSP. Reset enters IDLE.
- IDLE: `cmd_ready_o=1`. On `cmd_valid_i`, register `cmd_*` into the A-channel payload registers and go to REQ.
- REQ: `obi_req_o=1`, payload held constant. On `obi_gnt_i` go to RWAIT. `req` is never deasserted before `gnt`.
- RWAIT: `obi_rready_o=1`. On `obi_rvalid_i`, capture `obi_rdata_i` and `obi_err_i` into response registers and go to RSP.
- Write responses capture rdata too; the client ignores it.
- RSP: `rsp_valid_o=1`, response registers held. On `rsp_ready_i` go to IDLE.
- No bypass from RSP to REQ; next command is accepted in IDLE only.
- `obi_rvalid_i` outside RWAIT is ignored: no capture, no state change. This covers a subordinate asserting rvalid after its reset.
- `obi_gnt_i` outside REQ is ignored.
- Watchdog: stall counter of width clog2(TIMEOUT_CYCLES+1).
  - Increments each cycle in REQ or RWAIT; saturates at TIMEOUT_CYCLES.
  - Cleared on command acceptance.
  - `timeout_o` is set when the counter reaches TIMEOUT_CYCLES. It is cleared only by the next command acceptance or by reset.
  - Timeout does not abort the transaction, because OBI forbids retracting req.
- The payload registers keep their last value in IDLE. Only `obi_req_o` qualifies them.

## Timing
- Reset values: all outputs 0 except `cmd_ready_o=1` (IDLE). Counter 0, payload and response registers 0.
- All outputs are registered or decoded from state only. No combinational path from any input to any output.
- Command accepted at edge N → `obi_req_o=1` in cycle N+1.
- Grant sampled at edge N+1 → `obi_rready_o=1` in cycle N+2.
- rvalid sampled at edge N+2 → `rsp_valid_o=1` in cycle N+3.
- Minimum latency from command accept to `rsp_valid_o` is 3 cycles. Minimum command-to-command spacing is 4 cycles.
- `rsp_valid_o` is held until consumed; `rsp_rdata_o` and `rsp_err_o` are stable while valid.
- Reset asserted mid-transaction: immediate return to IDLE, `obi_req_o` and `obi_rready_o` drop asynchronously. Any response in flight is lost; this is the only permitted req retraction.

## Structure
- Package `obi_mgr_pkg` holds:
  - the `mgr_state_t` enum (IDLE=2'b00, REQ=2'b01, RWAIT=2'b10, RSP=2'b11);
  - the shared error pattern `OBI_ERR_RDATA=32'hBADCAB1E`, for use by benches.
- Sub-module `obi_stall_counter` contains the saturating counter and the sticky flag. Its inputs are enable, clear and the threshold parameter.

## Test plan
- Write then read, each against the team's SRAM subordinate:
  - write addr 0x4, be 0xF, wdata 0xDEADBEEF → response with err=0;
  - read addr 0x4 → `rsp_rdata_o=0xDEADBEEF`, `rsp_err_o=0`, `rsp_valid_o` exactly 3 cycles after accept.
- Read from out-of-range addr 0x100 → `rsp_err_o=1`, `rsp_rdata_o=0xBADCAB1E`.
- Grant withheld 5 cycles → `obi_req_o` stays high and addr/we/be/wdata stay constant every cycle until gnt. `timeout_o` stays 0 with TIMEOUT_CYCLES=255.
- TIMEOUT_CYCLES=4, rvalid withheld 10 cycles:
  - `timeout_o` rises in the 5th RWAIT cycle and the transaction still completes;
  - the next command accept clears `timeout_o`.
- Backpressure and spurious rvalid:
  - `rsp_ready_i` low for 3 cycles → response held, `cmd_ready_o=0`;
  - spurious `obi_rvalid_i` pulse in IDLE → no `rsp_valid_o`.
- Reset pulse while in REQ → `obi_req_o=0` immediately and `cmd_ready_o=1` after release; a fresh read then completes normally.

Source files
------------

// File: rtl/obi_mgr_pkg.sv
// obi_mgr_pkg: shared types and constants for the OBI manager and its benches.
package obi_mgr_pkg;

    // Manager transaction phases
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        REQ   = 2'b01,
        RWAIT = 2'b10,
        RSP   = 2'b11
    } mgr_state_t;

    // Read data returned by subordinates alongside an error response
    localparam logic [31:0] OBI_ERR_RDATA = 32'hBADCAB1E;

    // Width of a counter that must be able to hold the value threshold
    function automatic int unsigned stall_cnt_width(input int unsigned threshold);
        return $clog2(threshold + 1);
    endfunction

endpackage

// File: rtl/obi_stall_counter.sv
// obi_stall_counter: saturating stall counter with a sticky threshold flag.
module obi_stall_counter
    import obi_mgr_pkg::*;
#(
    parameter int unsigned THRESHOLD = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic flag
);

    localparam int unsigned W = stall_cnt_width(THRESHOLD);
    localparam logic [W-1:0] LIMIT = W'(THRESHOLD);

    logic [W-1:0] count;

    // Count stalled cycles up to the limit; the flag latches once the limit is held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            flag  <= 1'b0;
        end else if (clear) begin
            count <= '0;
            flag  <= 1'b0;
        end else begin
            if (enable && (count != LIMIT)) begin
                count <= count + W'(1);
            end
            if (count == LIMIT) begin
                flag <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/obi_manager.sv
// obi_manager: single-outstanding OBI initiator bridging a valid/ready command
// port to the OBI A and R channels, with one buffered response and a watchdog.
module obi_manager
    import obi_mgr_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_we_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_be_i,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    timeout_o,
    output logic                    obi_req_o,
    input  logic                    obi_gnt_i,
    output logic [ADDR_WIDTH-1:0]   obi_addr_o,
    output logic                    obi_we_o,
    output logic [DATA_WIDTH/8-1:0] obi_be_o,
    output logic [DATA_WIDTH-1:0]   obi_wdata_o,
    input  logic                    obi_rvalid_i,
    output logic                    obi_rready_o,
    input  logic [DATA_WIDTH-1:0]   obi_rdata_i,
    input  logic                    obi_err_i
);

    mgr_state_t state;
    logic       accept;
    logic       capture;
    logic       stalled;

    // Handshakes are qualified by the phase so that stray gnt/rvalid are ignored
    assign accept  = (state == IDLE)  && cmd_valid_i;
    assign capture = (state == RWAIT) && obi_rvalid_i;
    assign stalled = (state == REQ)   || (state == RWAIT);

    // Transaction FSM; every handshake output is a flop so no input reaches an output
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state        <= IDLE;
            cmd_ready_o  <= 1'b1;
            obi_req_o    <= 1'b0;
            obi_rready_o <= 1'b0;
            rsp_valid_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        state       <= REQ;
                        cmd_ready_o <= 1'b0;
                        obi_req_o   <= 1'b1;
                    end
                end
                REQ: begin
                    if (obi_gnt_i) begin
                        state        <= RWAIT;
                        obi_req_o    <= 1'b0;
                        obi_rready_o <= 1'b1;
                    end
                end
                RWAIT: begin
                    if (obi_rvalid_i) begin
                        state        <= RSP;
                        obi_rready_o <= 1'b0;
                        rsp_valid_o  <= 1'b1;
                    end
                end
                RSP: begin
                    if (rsp_ready_i) begin
                        state       <= IDLE;
                        rsp_valid_o <= 1'b0;
                        cmd_ready_o <= 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    cmd_ready_o  <= 1'b1;
                    obi_req_o    <= 1'b0;
                    obi_rready_o <= 1'b0;
                    rsp_valid_o  <= 1'b0;
                end
            endcase
        end
    end

    // A-channel payload is loaded only on acceptance, so it is stable for the whole REQ phase
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            obi_addr_o  <= '0;
            obi_we_o    <= 1'b0;
            obi_be_o    <= '0;
            obi_wdata_o <= '0;
        end else if (accept) begin
            obi_addr_o  <= cmd_addr_i;
            obi_we_o    <= cmd_we_i;
            obi_be_o    <= cmd_be_i;
            obi_wdata_o <= cmd_wdata_i;
        end
    end

    // Response buffer is written once per transaction and held until the client consumes it
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else if (capture) begin
            rsp_rdata_o <= obi_rdata_i;
            rsp_err_o   <= obi_err_i;
        end
    end

    // Watchdog only reports a stall; the transaction is never abandoned since req cannot be retracted
    obi_stall_counter #(
        .THRESHOLD (TIMEOUT_CYCLES)
    ) u_stall_counter (
        .clk    (clk_i),
        .rst    (reset_i),
        .enable (stalled),
        .clear  (accept),
        .flag   (timeout_o)
    );

endmodule

// File: tb/tb_obi_manager.sv
// tb_obi_manager: bench for obi_manager with an in-bench SRAM subordinate model.
`timescale 1ns/1ps
module tb_obi_manager;
    import obi_mgr_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_we    = 1'b0;
    logic [AW-1:0] cmd_addr  = '0;
    logic [BW-1:0] cmd_be    = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_ready = 1'b0;
    logic          gnt       = 1'b0;
    logic          rvalid    = 1'b0;
    logic [DW-1:0] rdata     = '0;
    logic          rerr      = 1'b0;

    logic          a_cmd_ready, a_rsp_valid, a_rsp_err, a_timeout, a_req, a_we, a_rready;
    logic [DW-1:0] a_rsp_rdata, a_wdata;
    logic [AW-1:0] a_addr;
    logic [BW-1:0] a_be;
    logic          b_cmd_ready, b_rsp_valid, b_rsp_err, b_timeout, b_req, b_we, b_rready;
    logic [DW-1:0] b_rsp_rdata, b_wdata;
    logic [AW-1:0] b_addr;
    logic [BW-1:0] b_be;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // SRAM subordinate contents: 64 words, byte addresses 0x00..0xFF
    logic [31:0] mem [0:63];

    obi_manager #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(255)) dut_a (
        .clk_i(clk), .reset_i(reset),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(a_cmd_ready), .cmd_we_i(cmd_we),
        .cmd_addr_i(cmd_addr), .cmd_be_i(cmd_be), .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(a_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(a_rsp_rdata),
        .rsp_err_o(a_rsp_err), .timeout_o(a_timeout),
        .obi_req_o(a_req), .obi_gnt_i(gnt), .obi_addr_o(a_addr), .obi_we_o(a_we),
        .obi_be_o(a_be), .obi_wdata_o(a_wdata), .obi_rvalid_i(rvalid),
        .obi_rready_o(a_rready), .obi_rdata_i(rdata), .obi_err_i(rerr)
    );

    // Second instance with a short watchdog, fed the same stimulus
    obi_manager #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)) dut_b (
        .clk_i(clk), .reset_i(reset),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(b_cmd_ready), .cmd_we_i(cmd_we),
        .cmd_addr_i(cmd_addr), .cmd_be_i(cmd_be), .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(b_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(b_rsp_rdata),
        .rsp_err_o(b_rsp_err), .timeout_o(b_timeout),
        .obi_req_o(b_req), .obi_gnt_i(gnt), .obi_addr_o(b_addr), .obi_we_o(b_we),
        .obi_be_o(b_be), .obi_wdata_o(b_wdata), .obi_rvalid_i(rvalid),
        .obi_rready_o(b_rready), .obi_rdata_i(rdata), .obi_err_i(rerr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic in_range(input logic [AW-1:0] addr);
        return addr < 32'h100;
    endfunction

    // One transaction, called at a negedge with the manager idle. The bench plays the
    // subordinate: grant after gd stall cycles, rvalid after rd RWAIT cycles, consume after bp.
    task automatic do_txn(input logic we, input logic [AW-1:0] addr, input logic [BW-1:0] be,
                          input logic [DW-1:0] wdata, input int gd, input int rd, input int bp,
                          input bit noise,
                          output logic [DW-1:0] got_d, output logic got_e, output logic [DW-1:0] sent_d,
                          output int lat, output int to_b_rwait, output logic to_b_req,
                          output logic to_a_seen, output int acc_cyc);
        logic [5:0] idx;
        idx        = addr[7:2];
        lat        = 0;
        to_b_rwait = 0;
        to_a_seen  = 1'b0;
        sent_d     = '0;
        acc_cyc    = cyc;
        checks++;
        if (a_cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL cmd_ready_at_accept got=%b expected=1", a_cmd_ready);
        end
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_be = be; cmd_wdata = wdata;
        @(negedge clk);
        lat = 1;
        cmd_valid = 1'b0;
        to_b_req  = b_timeout;
        for (int k = 0; k <= gd; k++) begin
            checks++;
            if (a_req !== 1'b1 || a_rready !== 1'b0 || a_cmd_ready !== 1'b0 || a_addr !== addr ||
                a_we !== we || a_be !== be || a_wdata !== wdata) begin
                failures++;
                $display("FAIL req_phase k=%0d req=%b rready=%b addr=%h we=%b be=%h wdata=%h expected req=1 addr=%h we=%b be=%h wdata=%h",
                         k, a_req, a_rready, a_addr, a_we, a_be, a_wdata, addr, we, be, wdata);
            end
            if (a_timeout) to_a_seen = 1'b1;
            gnt    = (k == gd);
            rvalid = noise ? 1'($urandom) : 1'b0;
            rdata  = $urandom;
            rerr   = 1'($urandom);
            if (noise) begin
                cmd_valid = 1'($urandom); cmd_we = 1'($urandom); cmd_addr = $urandom;
                cmd_be = 4'($urandom); cmd_wdata = $urandom;
            end
            @(negedge clk);
            lat++;
        end
        if (we && in_range(addr)) begin
            for (int b = 0; b < BW; b++) if (be[b]) mem[idx][8*b +: 8] = wdata[8*b +: 8];
        end
        for (int k = 0; k <= rd; k++) begin
            checks++;
            if (a_rready !== 1'b1 || a_req !== 1'b0 || a_rsp_valid !== 1'b0 || a_cmd_ready !== 1'b0) begin
                failures++;
                $display("FAIL rwait_phase k=%0d rready=%b req=%b rsp_valid=%b cmd_ready=%b expected 1 0 0 0",
                         k, a_rready, a_req, a_rsp_valid, a_cmd_ready);
            end
            if (b_timeout && to_b_rwait == 0) to_b_rwait = k + 1;
            if (a_timeout) to_a_seen = 1'b1;
            gnt = noise ? 1'($urandom) : 1'b0;
            if (noise) begin
                cmd_valid = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
            end
            if (k == rd) begin
                rvalid = 1'b1;
                if (!in_range(addr)) begin
                    rdata = OBI_ERR_RDATA; rerr = 1'b1;
                end else if (we) begin
                    rdata = $urandom; rerr = 1'b0;
                end else begin
                    rdata = mem[idx]; rerr = 1'b0;
                end
                sent_d = rdata;
            end else begin
                rvalid = 1'b0; rdata = $urandom; rerr = 1'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        cmd_valid = 1'b0;
        gnt       = noise ? 1'($urandom) : 1'b0;
        rvalid    = noise ? 1'($urandom) : 1'b0;
        rdata     = $urandom;
        rerr      = 1'($urandom);
        got_d     = a_rsp_rdata;
        got_e     = a_rsp_err;
        checks++;
        if (a_rsp_valid !== 1'b1 || a_cmd_ready !== 1'b0 || a_req !== 1'b0 || a_rready !== 1'b0) begin
            failures++;
            $display("FAIL rsp_phase rsp_valid=%b cmd_ready=%b req=%b rready=%b expected 1 0 0 0",
                     a_rsp_valid, a_cmd_ready, a_req, a_rready);
        end
        for (int k = 0; k < bp; k++) begin
            rsp_ready = 1'b0;
            @(negedge clk);
            checks++;
            if (a_rsp_valid !== 1'b1 || a_cmd_ready !== 1'b0 || a_rsp_rdata !== sent_d || a_rsp_err !== got_e) begin
                failures++;
                $display("FAIL rsp_hold k=%0d rsp_valid=%b cmd_ready=%b rdata=%h expected valid=1 ready=0 rdata=%h",
                         k, a_rsp_valid, a_cmd_ready, a_rsp_rdata, sent_d);
            end
            gnt    = noise ? 1'($urandom) : 1'b0;
            rvalid = noise ? 1'($urandom) : 1'b0;
            rdata  = $urandom;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0; gnt = 1'b0; rvalid = 1'b0;
        checks++;
        if (a_rsp_valid !== 1'b0 || a_cmd_ready !== 1'b1 || a_req !== 1'b0) begin
            failures++;
            $display("FAIL rsp_release rsp_valid=%b cmd_ready=%b req=%b expected 0 1 0",
                     a_rsp_valid, a_cmd_ready, a_req);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        repeat (3) @(negedge clk);
        checks++;
        if (a_cmd_ready !== 1'b1 || a_rsp_valid !== 1'b0 || a_rsp_err !== 1'b0 || a_rsp_rdata !== '0 ||
            a_timeout !== 1'b0 || a_req !== 1'b0 || a_addr !== '0 || a_we !== 1'b0 || a_be !== '0 ||
            a_wdata !== '0 || a_rready !== 1'b0) begin
            failures++;
            $display("FAIL reset_values_a cmd_ready=%b rsp_valid=%b req=%b rready=%b timeout=%b addr=%h rdata=%h expected ready=1 rest=0",
                     a_cmd_ready, a_rsp_valid, a_req, a_rready, a_timeout, a_addr, a_rsp_rdata);
        end
        checks++;
        if (b_cmd_ready !== 1'b1 || b_rsp_valid !== 1'b0 || b_rsp_err !== 1'b0 || b_rsp_rdata !== '0 ||
            b_timeout !== 1'b0 || b_req !== 1'b0 || b_addr !== '0 || b_we !== 1'b0 || b_be !== '0 ||
            b_wdata !== '0 || b_rready !== 1'b0) begin
            failures++;
            $display("FAIL reset_values_b cmd_ready=%b req=%b timeout=%b expected ready=1 rest=0",
                     b_cmd_ready, b_req, b_timeout);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (a_cmd_ready !== 1'b1 || a_req !== 1'b0 || a_rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset cmd_ready=%b req=%b rsp_valid=%b expected 1 0 0",
                     a_cmd_ready, a_req, a_rsp_valid);
        end
    endtask

    task automatic test_write_read();
        logic [DW-1:0] d, s; logic e, tq, ta; int lat, tr, ac;
        do_txn(1'b1, 32'h4, 4'hF, 32'hDEADBEEF, 0, 0, 0, 1'b0, d, e, s, lat, tr, tq, ta, ac);
        checks++;
        if (e !== 1'b0 || d !== s) begin
            failures++;
            $display("FAIL write_rsp err=%b rdata=%h expected err=0 rdata=%h", e, d, s);
        end
        do_txn(1'b0, 32'h4, 4'hF, 32'h0, 0, 0, 0, 1'b0, d, e, s, lat, tr, tq, ta, ac);
        checks++;
        if (d !== 32'hDEADBEEF || e !== 1'b0) begin
            failures++;
            $display("FAIL read_back rdata=%h err=%b expected DEADBEEF 0", d, e);
        end
        checks++;
        if (lat !== 3) begin
            failures++;
            $display("FAIL read_latency got=%0d expected=3", lat);
        end
    endtask

    task automatic test_out_of_range();
        logic [DW-1:0] d, s; logic e, tq, ta; int lat, tr, ac;
        do_txn(1'b0, 32'h100, 4'hF, 32'h0, 0, 0, 0, 1'b0, d, e, s, lat, tr, tq, ta, ac);
        checks++;
        if (d !== OBI_ERR_RDATA || e !== 1'b1) begin
            failures++;
            $display("FAIL out_of_range rdata=%h err=%b expected BADCAB1E 1", d, e);
        end
    endtask

    task automatic test_grant_stall();
        logic [DW-1:0] d, s; logic e, tq, ta; int lat, tr, ac;
        do_txn(1'b1, 32'h8, 4'h5, 32'hA5A5_5A5A, 5, 0, 0, 1'b0, d, e, s, lat, tr, tq, ta, ac);
        checks++;
        if (ta !== 1'b0 || e !== 1'b0 || lat !== 8) begin
            failures++;
            $display("FAIL grant_stall timeout_seen=%b err=%b latency=%0d expected 0 0 8", ta, e, lat);
        end
    endtask

    task automatic test_timeout();
        logic [DW-1:0] d, s; logic e, tq, ta; int lat, tr, ac;
        do_txn(1'b0, 32'h4, 4'hF, 32'h0, 0, 10, 0, 1'b0, d, e, s, lat, tr, tq, ta, ac);
        checks++;
        if (tr !== 5) begin
            failures++;
            $display("FAIL timeout_rise rwait_cycle=%0d expected=5", tr);
        end
        checks++;
        if (d !== 32'hDEADBEEF || e !== 1'b0 || lat !== 13 || ta !== 1'b0) begin
            failures++;
            $display("FAIL timeout_completion rdata=%h err=%b latency=%0d a_timeout=%b expected DEADBEEF 0 13 0",
                     d, e, lat, ta);
        end
        checks++;
        if (b_timeout !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky got=%b expected=1", b_timeout);
        end
        do_txn(1'b0, 32'h4, 4'hF, 32'h0, 0, 0, 0, 1'b0, d, e, s, lat, tr, tq, ta, ac);
        checks++;
        if (tq !== 1'b0) begin
            failures++;
            $display("FAIL timeout_clear_on_accept got=%b expected=0", tq);
        end
    endtask

    task automatic test_backpressure_spurious();
        logic [DW-1:0] d, s; logic e, tq, ta; int lat, tr, ac;
        do_txn(1'b0, 32'h4, 4'hF, 32'h0, 0, 0, 3, 1'b0, d, e, s, lat, tr, tq, ta, ac);
        checks++;
        if (d !== 32'hDEADBEEF || e !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_data rdata=%h err=%b expected DEADBEEF 0", d, e);
        end
        rvalid = 1'b1; rdata = 32'h1234_5678; rerr = 1'b1; gnt = 1'b1;
        @(negedge clk);
        rvalid = 1'b0; gnt = 1'b0; rerr = 1'b0;
        checks++;
        if (a_rsp_valid !== 1'b0 || a_cmd_ready !== 1'b1 || a_req !== 1'b0 || a_rready !== 1'b0) begin
            failures++;
            $display("FAIL spurious_state rsp_valid=%b cmd_ready=%b req=%b rready=%b expected 0 1 0 0",
                     a_rsp_valid, a_cmd_ready, a_req, a_rready);
        end
        checks++;
        if (a_rsp_rdata !== 32'hDEADBEEF || a_rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL spurious_capture rdata=%h err=%b expected DEADBEEF 0", a_rsp_rdata, a_rsp_err);
        end
    endtask

    task automatic test_reset_mid_req();
        logic [DW-1:0] d, s; logic e, tq, ta; int lat, tr, ac;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h4; cmd_be = 4'hF; cmd_wdata = '0;
        @(negedge clk);
        cmd_valid = 1'b0; gnt = 1'b0;
        checks++;
        if (a_req !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_pre_req got=%b expected=1", a_req);
        end
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        checks++;
        if (a_req !== 1'b0 || b_req !== 1'b0 || a_cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_drop req_a=%b req_b=%b cmd_ready=%b expected 0 0 1", a_req, b_req, a_cmd_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (a_cmd_ready !== 1'b1 || a_req !== 1'b0 || a_rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_release cmd_ready=%b req=%b rsp_valid=%b expected 1 0 0",
                     a_cmd_ready, a_req, a_rsp_valid);
        end
        do_txn(1'b0, 32'h4, 4'hF, 32'h0, 0, 0, 0, 1'b0, d, e, s, lat, tr, tq, ta, ac);
        checks++;
        if (d !== 32'hDEADBEEF || e !== 1'b0 || lat !== 3) begin
            failures++;
            $display("FAIL reset_mid_fresh_read rdata=%h err=%b latency=%0d expected DEADBEEF 0 3", d, e, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d, s; logic e, tq, ta; int lat, tr, ac, prev;
        logic [AW-1:0] addrs [4];
        logic [DW-1:0] vals [4];
        addrs[0] = 32'h10; addrs[1] = 32'h14; addrs[2] = 32'h10; addrs[3] = 32'h14;
        vals[0] = 32'h0102_0304; vals[1] = 32'hCAFE_F00D;
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            do_txn(i < 2, addrs[i], 4'hF, vals[i % 2], 0, 0, 0, 1'b0, d, e, s, lat, tr, tq, ta, ac);
            if (i >= 2) begin
                checks++;
                if (d !== vals[i % 2] || e !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_data i=%0d rdata=%h expected %h", i, d, vals[i % 2]);
                end
            end
            if (prev >= 0) begin
                checks++;
                if (ac - prev !== 4) begin
                    failures++;
                    $display("FAIL b2b_spacing i=%0d spacing=%0d expected=4", i, ac - prev);
                end
            end
            prev = ac;
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] d, s, exp_d; logic e, tq, ta, exp_e, we; int lat, tr, ac, gd, rd, bp;
        logic [AW-1:0] addr; logic [BW-1:0] be; logic [DW-1:0] wdata; logic [5:0] w;
        for (int i = 0; i < 40; i++) begin
            we    = 1'($urandom);
            w     = 6'($urandom);
            addr  = ($urandom_range(0, 5) == 0) ? (32'h100 + {24'h0, w, 2'b00}) : {24'h0, w, 2'b00};
            be    = 4'($urandom);
            wdata = $urandom;
            gd    = $urandom_range(0, 3);
            rd    = $urandom_range(0, 3);
            bp    = $urandom_range(0, 2);
            exp_e = !in_range(addr);
            exp_d = exp_e ? OBI_ERR_RDATA : mem[addr[7:2]];
            do_txn(we, addr, be, wdata, gd, rd, bp, 1'b1, d, e, s, lat, tr, tq, ta, ac);
            if (we && !exp_e) exp_d = s;
            checks++;
            if (d !== exp_d || e !== exp_e || lat !== 3 + gd + rd) begin
                failures++;
                $display("FAIL random i=%0d we=%b addr=%h rdata=%h err=%b latency=%0d expected %h %b %0d",
                         i, we, addr, d, e, lat, exp_d, exp_e, 3 + gd + rd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_out_of_range();
        test_grant_stall();
        test_timeout();
        test_backpressure_spurious();
        test_reset_mid_req();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

endmodule
